// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped UART-style TX FIFO, status and cycle counter.
// RAM at 0x000-0x1FF, TXDATA 0x200, STATUS 0x204, CYCLES 0x208.
module dmem_mmio #(
   parameter int n     = 10,
   parameter int m     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] addr,
   input  logic [m-1:0] write_data,
   input  logic         memwr,
   output logic [m-1:0] read_data,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready
);

   localparam int AW = $clog2(DEPTH);

   logic [n-1:0]  wa;
   logic          is_ram;
   logic          is_tx;
   logic          is_st;
   logic          is_cyc;

   logic [m-1:0]  ram [128];

   logic [7:0]    fifo [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   count;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          push;
   logic          push_ok;
   logic          pop;

   logic [31:0]   cycles;
   logic [2:0]    cnt3;
   logic [m-1:0]  status;

   // Word address: the byte offset is shifted out.
   assign wa     = addr >> 2;
   assign is_ram = wa < n'(128);
   assign is_tx  = wa == n'(128);
   assign is_st  = wa == n'(129);
   assign is_cyc = wa == n'(130);

   assign full     = count == (AW+1)'(DEPTH);
   assign empty    = count == '0;
   assign tx_valid = !empty;
   assign tx_data  = fifo[rp];

   assign pop     = tx_valid && tx_ready;
   assign push    = memwr && is_tx;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (memwr && is_ram) begin
         ram[wa[6:0]] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo[wp] <= write_data[7:0];
            wp       <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push_ok && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push_ok) begin
            count <= count - 1'b1;
         end
         if (push && full && !pop) begin
            ovf <= 1'b1;
         end else if (memwr && is_st && write_data[2]) begin
            ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycles <= '0;
      end else if (memwr && is_cyc) begin
         cycles <= 32'(write_data);
      end else begin
         cycles <= cycles + 32'd1;
      end
   end

   assign cnt3   = 3'(count);
   assign status = m'({cnt3, ovf, full, empty});

   always_comb begin
      read_data = '0;
      unique case (1'b1)
         is_ram:  read_data = ram[wa[6:0]];
         is_st:   read_data = status;
         is_cyc:  read_data = m'(cycles);
         default: read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected reads and TX bytes,
// a negedge monitor pops and compares them.
module tb_dmem_mmio;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] write_data = '0;
   logic        memwr = 1'b0;
   logic [31:0] read_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } rd_t;

   rd_t        rd_q[$];
   logic [7:0] tx_q[$];
   logic       rd_en = 1'b0;
   int         checks = 0;
   int         failures = 0;

   dmem_mmio dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .write_data (write_data),
      .memwr      (memwr),
      .read_data  (read_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      rd_t e;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rd_en) begin
            if (rd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_q: got read with no expectation");
            end else begin
               e = rd_q.pop_front();
               chk(e.name, read_data, e.exp);
            end
         end
         if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_extra: got byte %h want none", tx_data);
            end else begin
               b = tx_q.pop_front();
               chk("tx_byte", {24'h0, tx_data}, {24'h0, b});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      addr       = a;
      write_data = d;
      memwr      = 1'b1;
      step();
      memwr      = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] x,
                     input string nm);
      rd_t t;
      t.name = nm;
      t.exp  = x;
      rd_q.push_back(t);
      addr   = a;
      memwr  = 1'b0;
      rd_en  = 1'b1;
      step();
      rd_en  = 1'b0;
   endtask

   task automatic wr_rd(input logic [9:0] a, input logic [31:0] d,
                        input logic [31:0] old, input string nm);
      rd_t t;
      t.name = nm;
      t.exp  = old;
      rd_q.push_back(t);
      addr       = a;
      write_data = d;
      memwr      = 1'b1;
      rd_en      = 1'b1;
      step();
      memwr      = 1'b0;
      rd_en      = 1'b0;
   endtask

   task automatic drain(input string nm);
      tx_ready = 1'b1;
      for (int i = 0; i < 30 && tx_q.size() != 0; i++) step();
      chk(nm, tx_q.size(), 0);
      tx_ready = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b1;
      chk("rst_tx_valid", {31'h0, tx_valid}, 0);
      rd(10'h208, 32'h0, "rst_cycles");
      rd(10'h204, 32'h1, "rst_status");

      wr(10'h010, 32'h0BADF00D);
      wr(10'h014, 32'h12345678);
      wr(10'h100, 32'h0A0B0C0D);
      wr_rd(10'h010, 32'hDEADBEEF, 32'h0BADF00D, "rd_during_wr");
      rd(10'h010, 32'hDEADBEEF, "ram_010");
      rd(10'h012, 32'hDEADBEEF, "ram_012");
      rd(10'h014, 32'h12345678, "ram_014");

      addr       = 10'h200;
      write_data = 32'h41;
      memwr      = 1'b1;
      tx_q.push_back(8'h41);
      #2;
      chk("no_passthru", {31'h0, tx_valid}, 0);
      step();
      chk("valid_next", {31'h0, tx_valid}, 1);
      for (int i = 2; i <= 5; i++) begin
         wr(10'h200, 32'h40 + i);
         if (i <= 4) tx_q.push_back(8'(8'h40 + i));
      end
      rd(10'h204, 32'h26, "st_ovf_full");
      drain("drain1");
      rd(10'h204, 32'h05, "st_drained");

      wr(10'h204, 32'h4);
      rd(10'h204, 32'h01, "ovf_clear");
      rd(10'h300, 32'h0, "unmapped_300");
      rd(10'h20C, 32'h0, "unmapped_20c");
      rd(10'h200, 32'h0, "txdata_rd");
      wr(10'h300, 32'hFFFFFFFF);
      rd(10'h100, 32'h0A0B0C0D, "alias_ram");
      rd(10'h204, 32'h01, "unmapped_wr_st");

      for (int i = 1; i <= 4; i++) begin
         wr(10'h200, 32'h50 + i);
         tx_q.push_back(8'(8'h50 + i));
      end
      tx_q.push_back(8'h55);
      tx_ready = 1'b1;
      wr(10'h200, 32'h55);
      tx_ready = 1'b0;
      rd(10'h204, 32'h22, "full_pop_push");
      drain("drain2");
      rd(10'h204, 32'h01, "st_after_drain2");

      wr(10'h208, 32'hFFFFFFFE);
      rd(10'h208, 32'hFFFFFFFE, "cyc_load");
      rd(10'h208, 32'hFFFFFFFF, "cyc_max");
      rd(10'h208, 32'h00000000, "cyc_wrap");

      wr(10'h200, 32'h61);
      wr(10'h200, 32'h62);
      wr(10'h200, 32'h63);
      chk("queued_valid", {31'h0, tx_valid}, 1);
      rst        = 1'b0;
      addr       = 10'h208;
      write_data = 32'h1234;
      memwr      = 1'b1;
      step();
      rst   = 1'b1;
      memwr = 1'b0;
      chk("midrst_valid", {31'h0, tx_valid}, 0);
      rd(10'h208, 32'h0, "midrst_cycles");
      rd(10'h204, 32'h01, "midrst_status");
      rd(10'h010, 32'hDEADBEEF, "ram_kept");
      step();

      chk("rd_q_empty", rd_q.size(), 0);
      chk("tx_q_empty", tx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
